spi_memory_responder: RTL

- Synthesizable SPI mode-0 memory target (responder) answering the commands the CPU's SPI memory controller issues: 0x03 READ and 0x02 WRITE, each followed by a 24-bit address and a data stream.
- Backed by an internal byte array.
- Instantiated once with WRITABLE=0 on the flash chip-select and once with WRITABLE=1 on the PSRAM chip-select.
- Serves FPGA bring-up and the top-level bench as a stand-in for external flash/PSRAM.

---
 rtl/spi_memory_responder_pkg.sv | 13 +
 rtl/spi_resp_mem.sv | 33 +++
 rtl/spi_memory_responder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/spi_memory_responder_pkg.sv
// Shared SPI memory definitions.
// Command opcodes and memory target kinds.
package spi_memory_responder_pkg;

  typedef enum logic {
    MEM_FLASH = 1'b0,
    MEM_PSRAM = 1'b1
  } mem_type_t;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

endpackage

// File: rtl/spi_resp_mem.sv
// Byte array behind the SPI responder.
// Async read; SPI writes beat backdoor loads.
module spi_resp_mem #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk_in,
  input  logic                 spi_we,
  input  logic [ADDR_BITS-1:0] spi_addr,
  input  logic [7:0]           spi_data,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [7:0]           rd_data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [7:0] mem [DEPTH];

  // Per-entry write select, SPI commit has priority
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (spi_we && spi_addr == ADDR_BITS'(i))
        mem[i] <= spi_data;
      else if (load_en && load_addr == ADDR_BITS'(i))
        mem[i] <= load_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spi_memory_responder.sv
// SPI mode-0 memory target (READ 0x03 / WRITE 0x02).
// Stand-in for external flash (read-only) or PSRAM.
module spi_memory_responder
  import spi_memory_responder_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter bit WRITABLE  = 1'b1
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 sclk_in,
  input  logic                 mosi_in,
  input  logic                 cs_in,
  output logic                 miso_out,
  input  logic                 load_en_in,
  input  logic [ADDR_BITS-1:0] load_addr_in,
  input  logic [7:0]           load_data_in,
  output logic                 wr_valid_out,
  output logic [ADDR_BITS-1:0] wr_addr_out,
  output logic [7:0]           wr_data_out,
  output logic                 busy_out
);

  localparam int SW = (ADDR_BITS > 8) ? ADDR_BITS : 8;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR,
    S_READ, S_WRITE, S_IGNORE
  } state_t;

  state_t state_q, state_d;

  logic                 sclk_q;
  logic                 rise;
  logic [4:0]           cnt_q, cnt_d;
  logic [SW-2:0]        sh_q, sh_d;
  logic [SW-1:0]        sh_nxt;
  logic [7:0]           byte_nxt;
  logic [ADDR_BITS-1:0] addr_nxt;
  logic [6:0]           out_q, out_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic                 rd_q, rd_d;
  logic                 miso_d;
  logic                 wr_valid_d;
  logic [ADDR_BITS-1:0] wr_addr_d;
  logic [7:0]           wr_data_d;
  logic                 last8, last24;
  logic                 spi_we;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [7:0]           rd_data;

  assign rise     = sclk_in & ~sclk_q & ~cs_in;
  assign sh_nxt   = {sh_q, mosi_in};
  assign byte_nxt = sh_nxt[7:0];
  assign addr_nxt = sh_nxt[ADDR_BITS-1:0];
  assign last8    = rise && (cnt_q == 5'd7);
  assign last24   = rise && (cnt_q == 5'd23);
  assign spi_we   = (state_q == S_WRITE) && last8;
  assign rd_addr  = (state_q == S_ADDR) ? addr_nxt : ptr_q;

  spi_resp_mem #(
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk_in    (clk_in),
    .spi_we    (spi_we),
    .spi_addr  (ptr_q),
    .spi_data  (byte_nxt),
    .load_en   (load_en_in),
    .load_addr (load_addr_in),
    .load_data (load_data_in),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  // State register
  always_ff @(posedge clk_in) begin
    if (reset_in) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: command decode and phase sequencing
  always_comb begin
    state_d = state_q;
    if (cs_in) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_CMD;
        S_CMD: begin
          if (last8) begin
            if (byte_nxt == SPI_CMD_READ)
              state_d = S_ADDR;
            else if (byte_nxt == SPI_CMD_WRITE && WRITABLE)
              state_d = S_ADDR;
            else
              state_d = S_IGNORE;
          end
        end
        S_ADDR: begin
          if (last24) state_d = rd_q ? S_READ : S_WRITE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs and datapath next values per state
  always_comb begin
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    out_d      = out_q;
    ptr_d      = ptr_q;
    rd_d       = rd_q;
    miso_d     = miso_out;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_out;
    wr_data_d  = wr_data_out;
    if (cs_in) begin
      cnt_d  = 5'd0;
      miso_d = 1'b0;
    end else if (rise) begin
      sh_d  = sh_nxt[SW-2:0];
      cnt_d = cnt_q + 5'd1;
      unique case (state_q)
        S_CMD: begin
          if (last8) begin
            cnt_d = 5'd0;
            rd_d  = (byte_nxt == SPI_CMD_READ);
          end
        end
        S_ADDR: begin
          if (last24) begin
            cnt_d = 5'd0;
            if (rd_q) begin
              out_d  = rd_data[6:0];
              miso_d = rd_data[7];
              ptr_d  = addr_nxt + 1'b1;
            end else begin
              ptr_d  = addr_nxt;
            end
          end
        end
        S_READ: begin
          if (last8) begin
            cnt_d  = 5'd0;
            out_d  = rd_data[6:0];
            miso_d = rd_data[7];
            ptr_d  = ptr_q + 1'b1;
          end else begin
            out_d  = {out_q[5:0], 1'b0};
            miso_d = out_q[6];
          end
        end
        S_WRITE: begin
          if (last8) begin
            cnt_d      = 5'd0;
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = byte_nxt;
            ptr_d      = ptr_q + 1'b1;
          end
        end
        S_IGNORE: cnt_d = cnt_q;
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sclk_q       <= 1'b0;
      cnt_q        <= 5'd0;
      sh_q         <= '0;
      out_q        <= '0;
      ptr_q        <= '0;
      rd_q         <= 1'b0;
      miso_out     <= 1'b0;
      wr_valid_out <= 1'b0;
      wr_addr_out  <= '0;
      wr_data_out  <= '0;
      busy_out     <= 1'b0;
    end else begin
      sclk_q       <= sclk_in;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      out_q        <= out_d;
      ptr_q        <= ptr_d;
      rd_q         <= rd_d;
      miso_out     <= miso_d;
      wr_valid_out <= wr_valid_d;
      wr_addr_out  <= wr_addr_d;
      wr_data_out  <= wr_data_d;
      busy_out     <= ~cs_in;
    end
  end

endmodule
